totient_engine: RTL

Iterative sequential calculator that computes Euler's totient phi(n) for an unsigned input n. It counts the k in 1..n with gcd(n,k)==1, using subtractive Euclid on a shared datapath.
Sits directly upstream of the EulerTotient seven-segment display stage and supplies the phi value it renders.
Start/busy/done handshake. Result is held stable between computations.

---
 rtl/totient_engine.sv | 112 +++++++++++
 1 files changed

// File: rtl/totient_engine.sv
// Purpose : iterative Euler totient phi(n) using subtractive Euclid on one shared datapath.
// Latency : done pulses L = 2 + sum_{k=1..n}(S_k + 1) cycles after start is accepted (S_k = subtraction steps for gcd(n,k)).
// Backpres: none; start is sampled only in IDLE, requests seen while busy are dropped.
`timescale 1ns/1ps
module totient_engine #(
    parameter int W = 8
) (
    input  logic         clk_0,
    input  logic         R,
    input  logic         start,
    input  logic [W-1:0] n_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] phi_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] ZERO = '0;

    state_t       state;
    logic [W-1:0] n;      // operand captured on the accepted start
    logic [W-1:0] k;      // candidate currently being tested against n
    logic [W-1:0] a;      // Euclid working value, starts at n
    logic [W-1:0] b;      // Euclid working value, starts at k
    logic [W-1:0] count;  // number of k found coprime so far

    // Next k, only used when k < n so it never wraps.
    logic [W-1:0] k_next;
    assign k_next = k + ONE;

    // Whole controller and datapath: one step of the algorithm per clock, outputs registered.
    always_ff @(posedge clk_0) begin
        if (R) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            phi_out <= ZERO;
            n       <= ZERO;
            k       <= ZERO;
            a       <= ZERO;
            b       <= ZERO;
            count   <= ZERO;
        end else begin
            // done is a single-cycle pulse; only the DONE state raises it.
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n     <= n_in;
                        state <= S_INIT;
                        busy  <= 1'b1;
                    end
                end

                S_INIT: begin
                    count <= ZERO;
                    if (n == ZERO) begin
                        // phi(0) is defined as 0: skip the loop entirely.
                        state <= S_DONE;
                    end else begin
                        k     <= ONE;
                        a     <= n;
                        b     <= ONE;
                        state <= S_STEP;
                    end
                end

                S_STEP: begin
                    if (a > b) begin
                        a <= a - b;
                    end else if (a < b) begin
                        b <= b - a;
                    end else begin
                        // a == b is gcd(n,k); gcd of 1 means k is coprime to n.
                        if (a == ONE) begin
                            count <= count + ONE;
                        end
                        if (k == n) begin
                            state <= S_DONE;
                        end else begin
                            // Reload for the next k in the same cycle, no separate load state.
                            k <= k_next;
                            a <= n;
                            b <= k_next;
                        end
                    end
                end

                S_DONE: begin
                    // count already includes the final increment made on the last STEP.
                    phi_out <= count;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
